// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit: the carry chain is cut into STAGES slices,
// one register stage per slice, with valid/ready flow control on both sides.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);

    localparam int SW = WIDTH / STAGES;

    logic             advance;
    logic [STAGES-1:0] valid_q, carry_q;
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] res_q [STAGES];
    logic             ovf_q;

    logic [STAGES-1:0] valid_src, cin_src, cout_nxt;
    logic [WIDTH-1:0] a_src   [STAGES];
    logic [WIDTH-1:0] b_src   [STAGES];
    logic [WIDTH-1:0] res_src [STAGES];
    logic [WIDTH-1:0] a_nxt   [STAGES];
    logic [WIDTH-1:0] b_nxt   [STAGES];
    logic [WIDTH-1:0] res_nxt [STAGES];
    logic [SW:0]      slice_sum [STAGES];
    logic             msb_cin, ovf_nxt;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Operand skew registers are kept right-aligned: each stage consumes the low SW
    // bits and shifts the remainder down, so the next slice is always at [SW-1:0].
    always_comb begin
        valid_src[0] = in_valid;
        a_src[0]     = a_in;
        b_src[0]     = sub_in ? ~b_in : b_in;
        cin_src[0]   = sub_in ? ~c_in : c_in;
        res_src[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            valid_src[k] = valid_q[k-1];
            a_src[k]     = a_q[k-1];
            b_src[k]     = b_q[k-1];
            cin_src[k]   = carry_q[k-1];
            res_src[k]   = res_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, a_src[k][SW-1:0]} + {1'b0, b_src[k][SW-1:0]}
                         + {{SW{1'b0}}, cin_src[k]};
            cout_nxt[k]  = slice_sum[k][SW];
            a_nxt[k]     = a_src[k] >> SW;
            b_nxt[k]     = b_src[k] >> SW;
            res_nxt[k]   = res_src[k];
            res_nxt[k][k*SW +: SW] = slice_sum[k][SW-1:0];
        end
        // Carry into the MSB is recovered from the MSB's own sum bit and operands.
        msb_cin = a_src[STAGES-1][SW-1] ^ b_src[STAGES-1][SW-1]
                ^ slice_sum[STAGES-1][SW-1];
        ovf_nxt = msb_cin ^ cout_nxt[STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; blocking here would collapse the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are cleared too, not just valid bits, because the
            // outputs must read as zero during and right after reset.
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_src;
            carry_q <= cout_nxt;
            ovf_q   <= ovf_nxt;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_nxt[k];
                b_q[k]   <= b_nxt[k];
                res_q[k] <= res_nxt[k];
            end
        end
    end

    assign out_valid    = valid_q[STAGES-1];
    assign sum_out      = res_q[STAGES-1];
    assign carry_out    = carry_q[STAGES-1];
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=16, STAGES=4):
// reset, ripple latency, subtract overflow, streaming, backpressure, mid-stream reset.
module tb_pipelined_adder;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        sub;
        logic [15:0] sum;
        logic        cy;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        c_in = 1'b0;
    logic        sub_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum_out;
    logic        carry_out;
    logic        overflow_out;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs [8];
    vec_t v_ripple, v_sub1, v_sub2;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .c_in         (c_in),
        .sub_in       (sub_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sum_out      (sum_out),
        .carry_out    (carry_out),
        .overflow_out (overflow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a_in     = v.a;
        b_in     = v.b;
        c_in     = v.c;
        sub_in   = v.sub;
        in_valid = 1'b1;
    endtask

    task automatic expect_out(input string tag, input vec_t v);
        check({tag, " valid"},    32'(out_valid),    32'd1);
        check({tag, " sum"},      32'(sum_out),      32'(v.sum));
        check({tag, " carry"},    32'(carry_out),    32'(v.cy));
        check({tag, " overflow"}, 32'(overflow_out), 32'(v.ov));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " out_valid"}, 32'(out_valid),    32'd0);
        check({tag, " sum"},       32'(sum_out),      32'd0);
        check({tag, " carry"},     32'(carry_out),    32'd0);
        check({tag, " overflow"},  32'(overflow_out), 32'd0);
        check({tag, " in_ready"},  32'(in_ready),     32'd1);
    endtask

    // Caller sits on a negedge with an empty pipeline; counts negedges until out_valid.
    task automatic single_op(input string tag, input vec_t v, input int exp_lat);
        int lat = 0;
        drive(v);
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 10);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        expect_out(tag, v);
        @(negedge clk);
        check({tag, " drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        //            a        b        c     sub   sum      cy    ov
        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{16'h5000, 16'h2000, 1'b0, 1'b1, 16'h3000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        v_ripple = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        v_sub1   = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        v_sub2   = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};

        // Reset asserted mid-cycle, before any clock edge.
        #1 rst_n = 1'b0;
        #2 check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        single_op("ripple", v_ripple, 4);
        single_op("sub_ovf", v_sub1, 4);
        single_op("sub_borrow", v_sub2, 4);

        // Back-to-back stream: result i is visible four negedges after it is driven.
        for (int i = 0; i < 13; i++) begin
            if (i < 8) drive(vecs[i]);
            else in_valid = 1'b0;
            #1;
            if (i >= 4 && i < 12) expect_out($sformatf("stream%0d", i - 4), vecs[i-4]);
            else check($sformatf("stream idle%0d", i), 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // Backpressure: fill four stages, stall three edges, then drain.
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i]);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("bp stall0 in_ready", 32'(in_ready), 32'd0);
        expect_out("bp hold0", vecs[0]);
        for (int s = 1; s <= 3; s++) begin
            @(negedge clk);
            check($sformatf("bp stall%0d in_ready", s), 32'(in_ready), 32'd0);
            expect_out($sformatf("bp hold%0d", s), vecs[0]);
        end
        out_ready = 1'b1;
        #1 check("bp release in_ready", 32'(in_ready), 32'd1);
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            expect_out($sformatf("bp drain%0d", j), vecs[j]);
        end
        @(negedge clk);
        check("bp no duplicate", 32'(out_valid), 32'd0);

        // Reset with three transactions in flight (one already at the output).
        for (int i = 4; i < 7; i++) begin
            drive(vecs[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        expect_out("pre-reset head", vecs[4]);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("mid reset");
        @(negedge clk);
        check_zero_outputs("reset held");
        @(negedge clk);
        rst_n = 1'b1;
        drive(vecs[7]);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("post-reset stale%0d", i), 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        expect_out("post-reset", vecs[7]);
        @(negedge clk);
        check("post-reset drained", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined WIDTH-bit add/subtract unit with valid/ready handshakes on input and output. The carry chain is split into STAGES equal slices, one per register stage. Each stage resolves one slice and passes its carry forward. The block sustains one operation per clock and is the arithmetic datapath element placed between operand-producing and result-consuming blocks in the design.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4: pipeline depth and number of carry-chain slices; 1 ≤ STAGES ≤ WIDTH. Slice width is SW = WIDTH/STAGES.

- clk  input  1  sole clock; all registers on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands and mode present this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- c_in  input  1  carry-in (add) or borrow-in (sub).
- sub_in  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result this cycle.
- sum_out  output  WIDTH  result.
- carry_out  output  1  carry out of MSB; in subtract it is 1 when no borrow occurred.
- overflow_out  output  1  two's-complement signed overflow.

## Operation
- **Arithmetic**
  - Add: {carry_out, sum_out} = a_in + b_in + c_in.
  - Sub: {carry_out, sum_out} = a_in + ~b_in + ~c_in, which equals a_in − b_in − c_in modulo 2^WIDTH.
  - overflow_out = (carry into MSB) XOR (carry out of MSB).
- **Slicing**
  - Stage k (k = 0..STAGES−1) adds bits [k·SW +: SW] of A and of B' (B' = sub_in ? ~b_in : b_in) to the carry registered by stage k−1.
  - Stage 0 takes its carry-in directly: c_in for add, ~c_in for subtract.
  - Operand slices not yet consumed travel alongside in skew registers.
  - Result slices already produced travel alongside until output.
- **Overflow generation:** the final stage computes the MSB carry-in and carry-out and registers overflow_out.
- **Per-stage state:** each stage holds a valid bit. A stage's valid bit loads the previous stage's valid when the pipeline advances.
- **Pipeline advance**
  - advance = !out_valid || out_ready.
  - in_ready = advance. This is combinational from out_ready and out_valid only and never depends on in_valid.
  - Acceptance occurs when in_valid && in_ready.
  - When advance = 0, every stage holds its contents, including data, carry and valid.
- **Bubbles:** bubbles (in_valid = 0 while advancing) move through as invalid stages. Results emerge in acceptance order, with no reordering, loss or duplication.
- **Reset**
  - rst_n low clears all valid bits, carries and data registers to 0, immediately and asynchronously.
  - Outputs during and after reset: out_valid = 0, sum_out = 0, carry_out = 0, overflow_out = 0. in_ready = 1 (because out_valid = 0).
  - A transaction in flight when reset asserts is discarded.
- **No separate control FSM:** the valid-bit chain is the only control state.

## Timing
- **Latency:** operands accepted at rising edge T produce out_valid = 1 with their result after edge T+STAGES−1. The result is visible in the cycle following edge T+STAGES−1. With STAGES = 1, the result is registered at the accepting edge.
- **Throughput:** one result per cycle while out_ready = 1.
- **Stall**
  - out_valid = 1 with out_ready = 0 forces in_ready = 0 in the same cycle.
  - sum_out, carry_out and overflow_out stay stable until the cycle in which out_ready = 1.
- **Simultaneous events:** out_valid = 1, out_ready = 1 and in_valid = 1 in one cycle means the output is consumed and a new input is accepted at the same edge.
- **Output changes:** outputs change only on rising clk edges or asynchronously on rst_n assertion.
- **Reset release:** the first acceptance is possible at the first rising edge with rst_n = 1.

## Test plan
All scenarios use WIDTH = 16, STAGES = 4.
- **Reset values:** assert rst_n = 0 mid-cycle → out_valid, sum_out, carry_out and overflow_out all 0 without a clock edge; in_ready = 1.
- **Full carry ripple:** a = 0xFFFF, b = 0x0001, c_in = 0, add → sum 0x0000, carry 1, overflow 0. out_valid rises 4 cycles after acceptance, proving carry crosses all slices.
- **Subtract with signed overflow:** a = 0x8000, b = 0x0001, c_in = 0, sub → sum 0x7FFF, carry 1, overflow 1. Then a = 0x0000, b = 0x0001, c_in = 1, sub → sum 0xFFFE, carry 0, overflow 0.
- **Back-to-back stream:** 8 back-to-back random add/sub transactions with out_ready = 1 → 8 consecutive out_valid cycles, results in order, each matching the reference model.
- **Backpressure:** fill the pipeline, then hold out_ready = 0 for 3 cycles → in_ready = 0 for those cycles and sum_out held stable. After release, all 4 results emerge in order with none lost or duplicated.
- **Reset mid-stream:** assert reset with 3 transactions in flight → out_valid drops at once. After release, only post-reset transactions appear, with no stale results.
